// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache-line to pmem-burst adaptor.
// Pure declarations; no latency or flow control of its own.
package cacheline_adaptor_pkg;

   localparam int CACHE_LINE_WIDTH = 256;
   localparam int BURST_LEN        = 4;
   localparam int ADDR_WIDTH       = 32;
   localparam int BW               = CACHE_LINE_WIDTH / BURST_LEN;
   localparam int OFFS             = $clog2(CACHE_LINE_WIDTH / 8);
   localparam int CNT_W            = $clog2(BURST_LEN);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, HIT} cla_state_e;

   typedef logic [CACHE_LINE_WIDTH-1:0]  line_t;
   typedef logic [BW-1:0]                beat_t;
   typedef logic [ADDR_WIDTH-1:0]        addr_t;
   typedef logic [ADDR_WIDTH-OFFS-1:0]   tag_t;
   typedef logic [CNT_W-1:0]             cnt_t;

   localparam cnt_t  CNT_LAST  = cnt_t'(BURST_LEN - 1);
   localparam addr_t ADDR_MASK = ~addr_t'((1 << OFFS) - 1);

   // Byte address -> address of the first byte of its cache line.
   function automatic addr_t line_base(input addr_t a);
      return a & ADDR_MASK;
   endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and pmem-side signal bundle; slave is the adaptor's view, master the environment's.
// Requests are held until resp_o; pmem paces beats with resp_i.
interface cacheline_adaptor_if;
   import cacheline_adaptor_pkg::*;

   addr_t address_i;
   logic  read_i;
   logic  write_i;
   line_t line_i;
   line_t line_o;
   logic  resp_o;

   addr_t address_o;
   logic  read_o;
   logic  write_o;
   beat_t burst_o;
   beat_t burst_i;
   logic  resp_i;

   modport slave (
      input  address_i, read_i, write_i, line_i, burst_i, resp_i,
      output line_o, resp_o, address_o, read_o, write_o, burst_o
   );

   modport master (
      output address_i, read_i, write_i, line_i, burst_i, resp_i,
      input  line_o, resp_o, address_o, read_o, write_o, burst_o
   );

endinterface

// File: rtl/cla_line_buffer.sv
// One-entry line buffer (tag, valid, data): combinational lookup, fill on any cycle fill_en is high.
// Lookup is zero latency; fill never stalls.
module cla_line_buffer
   import cacheline_adaptor_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  tag_t  lookup_tag,
   output logic  hit,
   output line_t rd_line,
   input  logic  fill_en,
   input  tag_t  fill_tag,
   input  line_t fill_line
);

   logic  vld_q;
   tag_t  tag_q;
   line_t data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         tag_q  <= '0;
         data_q <= '0;
      end else if (fill_en) begin
         vld_q  <= 1'b1;
         tag_q  <= fill_tag;
         data_q <= fill_line;
      end
   end

   assign hit     = vld_q && (tag_q == lookup_tag);
   assign rd_line = data_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Whole-line cache port <-> BURST_LEN-beat pmem port; pmem request 1 cycle after the cache request, resp_o 1 cycle
// after the last beat; pmem stalls by holding resp_i low. Optional one-line read buffer: CACHELINE_ADAPTOR_LINE_BUF_EN.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cacheline_adaptor_if.slave bus
);

   cla_state_e state_q;
   cla_state_e state_d;
   cnt_t       cnt_q;
   addr_t      addr_q;
   line_t      rline_q;
   line_t      wline_q;
   logic       beat_last;
   logic       beat_take;
   logic       req_take;

   assign beat_last = (cnt_q == CNT_LAST);
   assign beat_take = bus.resp_i && ((state_q == READ) || (state_q == WRITE));
   assign req_take  = (state_q == IDLE) && (bus.read_i || bus.write_i);

`ifdef CACHELINE_ADAPTOR_LINE_BUF_EN
   logic  buf_hit;
   line_t buf_line;
   logic  op_wr_q;

   // Reads fill from the assembled line, writes from the latched write line.
   cla_line_buffer u_line_buffer (
      .clk        (clk),
      .rst        (rst),
      .lookup_tag (bus.address_i[ADDR_WIDTH-1:OFFS]),
      .hit        (buf_hit),
      .rd_line    (buf_line),
      .fill_en    (state_q == DONE),
      .fill_tag   (addr_q[ADDR_WIDTH-1:OFFS]),
      .fill_line  (op_wr_q ? wline_q : rline_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr_q <= 1'b0;
      end else if (req_take) begin
         op_wr_q <= bus.write_i;
      end
   end

   assign bus.line_o = (state_q == HIT) ? buf_line : rline_q;
`else
   assign bus.line_o = rline_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Write takes priority when the cache raises both requests.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.write_i) begin
               state_d = WRITE;
            end else if (bus.read_i) begin
`ifdef CACHELINE_ADAPTOR_LINE_BUF_EN
               state_d = buf_hit ? HIT : READ;
`else
               state_d = READ;
`endif
            end
         end
         READ, WRITE: begin
            if (bus.resp_i && beat_last) begin
               state_d = DONE;
            end
         end
         DONE, HIT: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         rline_q <= '0;
         wline_q <= '0;
      end else begin
         if (req_take) begin
            addr_q <= line_base(bus.address_i);
         end
         if ((state_q == IDLE) && bus.write_i) begin
            wline_q <= bus.line_i;
         end
         if (beat_take) begin
            cnt_q <= beat_last ? '0 : cnt_q + cnt_t'(1);
            if (state_q == READ) begin
               rline_q[int'(cnt_q)*BW +: BW] <= bus.burst_i;
            end
         end
      end
   end

   assign bus.read_o    = (state_q == READ);
   assign bus.write_o   = (state_q == WRITE);
   assign bus.resp_o    = (state_q == DONE) || (state_q == HIT);
   assign bus.address_o = addr_q;
   assign bus.burst_o   = (state_q == WRITE) ? wline_q[int'(cnt_q)*BW +: BW] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: acts as cache and pmem, scoreboards resp_o and write beats.
// Works with or without CACHELINE_ADAPTOR_LINE_BUF_EN.
module tb_cacheline_adaptor;
   import cacheline_adaptor_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cacheline_adaptor_if bus ();

   cacheline_adaptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      addr_t addr;
      line_t line;
      bit    chk_line;
   } exp_t;

   exp_t  exp_q[$];
   beat_t beat_q[$];
   exp_t  mon_e;
   beat_t mon_b;
   int    checks = 0;
   int    errors = 0;

   task automatic report(input string name, input bit ok, input line_t act, input line_t exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      report(name, act === exp, line_t'(act), line_t'(exp));
   endtask

   task automatic chk_a(input string name, input addr_t act, input addr_t exp);
      report(name, act === exp, line_t'(act), line_t'(exp));
   endtask

   task automatic chk_d(input string name, input beat_t act, input beat_t exp);
      report(name, act === exp, line_t'(act), line_t'(exp));
   endtask

   task automatic chk_l(input string name, input line_t act, input line_t exp);
      report(name, act === exp, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every resp_o cycle and every accepted write beat is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && bus.resp_o) begin
         if (exp_q.size() == 0) begin
            report("resp_unexpected", 1'b0, line_t'(bus.resp_o), '0);
         end else begin
            mon_e = exp_q.pop_front();
            chk_a("resp_address", bus.address_o, mon_e.addr);
            if (mon_e.chk_line) chk_l("resp_line", bus.line_o, mon_e.line);
         end
      end
      if (!rst && bus.write_o && bus.resp_i) begin
         if (beat_q.size() == 0) begin
            report("beat_unexpected", 1'b0, line_t'(bus.burst_o), '0);
         end else begin
            mon_b = beat_q.pop_front();
            chk_d("burst_o", bus.burst_o, mon_b);
         end
      end
      if (bus.read_o && bus.write_o) report("rd_wr_overlap", 1'b0, line_t'(1), '0);
   end

   task automatic do_read(input addr_t a, input addr_t ea, input line_t l, input int gap_at, input bit hit);
      bus.address_i = a;
      bus.read_i    = 1'b1;
      exp_q.push_back('{addr: ea, line: l, chk_line: 1'b1});
      step();
      if (hit) begin
         chk_b("hit_resp", bus.resp_o, 1'b1);
         chk_b("hit_no_read", bus.read_o, 1'b0);
         bus.read_i = 1'b0;
         step();
         chk_b("hit_resp_one_cycle", bus.resp_o, 1'b0);
         return;
      end
      chk_b("rd_read_o", bus.read_o, 1'b1);
      chk_a("rd_address_o", bus.address_o, ea);
      for (int i = 0; i < BURST_LEN; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < 3; g++) begin
               bus.resp_i  = 1'b0;
               bus.burst_i = '1;
               step();
               chk_b("gap_read_o", bus.read_o, 1'b1);
               chk_a("gap_address_o", bus.address_o, ea);
            end
         end
         bus.resp_i  = 1'b1;
         bus.burst_i = l[i*BW +: BW];
         step();
      end
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      chk_b("rd_read_o_drop", bus.read_o, 1'b0);
      chk_b("rd_resp", bus.resp_o, 1'b1);
      bus.read_i = 1'b0;
      step();
      chk_b("rd_resp_one_cycle", bus.resp_o, 1'b0);
   endtask

   task automatic do_write(input addr_t a, input addr_t ea, input line_t l, input bit also_read);
      bus.address_i = a;
      bus.line_i    = l;
      bus.write_i   = 1'b1;
      bus.read_i    = also_read;
      exp_q.push_back('{addr: ea, line: l, chk_line: 1'b0});
      for (int i = 0; i < BURST_LEN; i++) beat_q.push_back(l[i*BW +: BW]);
      step();
      chk_b("wr_write_o", bus.write_o, 1'b1);
      chk_b("wr_no_read", bus.read_o, 1'b0);
      chk_a("wr_address_o", bus.address_o, ea);
      chk_d("wr_beat0_early", bus.burst_o, l[BW-1:0]);
      for (int i = 0; i < BURST_LEN; i++) begin
         bus.resp_i = 1'b1;
         step();
         chk_b("wr_no_read_beat", bus.read_o, 1'b0);
      end
      bus.resp_i = 1'b0;
      chk_b("wr_write_o_drop", bus.write_o, 1'b0);
      chk_b("wr_resp", bus.resp_o, 1'b1);
      bus.write_i = 1'b0;
      bus.read_i  = 1'b0;
      step();
      chk_b("wr_resp_one_cycle", bus.resp_o, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1);
   end

   initial begin
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.line_i    = '0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;

      step();
      step();
      chk_b("rst_read_o", bus.read_o, 1'b0);
      chk_b("rst_write_o", bus.write_o, 1'b0);
      chk_b("rst_resp_o", bus.resp_o, 1'b0);
      chk_a("rst_address_o", bus.address_o, 32'h0);
      chk_l("rst_line_o", bus.line_o, '0);
      chk_d("rst_burst_o", bus.burst_o, 64'h0);
      rst = 1'b0;
      step();

      do_read(32'h0000_0064, 32'h0000_0060,
              256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, -1, 1'b0);

      do_write(32'h0000_0100, 32'h0000_0100,
               256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA, 1'b0);

      do_write(32'h0000_01C4, 32'h0000_01C0,
               256'h0F0E0D0C0B0A0908_0706050403020100_FEDCBA9876543210_0123456789ABCDEF, 1'b1);

      do_read(32'h0000_0088, 32'h0000_0080,
              256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555, 2, 1'b0);

      // Reset one beat into a read: no completion, partial line thrown away.
      bus.address_i = 32'h0000_0300;
      bus.read_i    = 1'b1;
      step();
      chk_b("rst_mid_read_o", bus.read_o, 1'b1);
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h9999999999999999;
      step();
      rst = 1'b1;
      bus.burst_i = 64'h5A5A5A5A5A5A5A5A;
      step();
      chk_b("rst_mid_read_o_drop", bus.read_o, 1'b0);
      chk_b("rst_mid_no_resp", bus.resp_o, 1'b0);
      chk_l("rst_mid_line_discard", bus.line_o, '0);
      rst         = 1'b0;
      bus.read_i  = 1'b0;
      bus.burst_i = 64'hFFFFFFFFFFFFFFFF;
      repeat (3) step();
      chk_b("idle_resp_i_read_o", bus.read_o, 1'b0);
      chk_b("idle_resp_i_write_o", bus.write_o, 1'b0);
      chk_b("idle_resp_i_resp_o", bus.resp_o, 1'b0);
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      step();

      do_read(32'h0000_0200, 32'h0000_0200,
              256'hD4D4D4D4D4D4D4D4_C3C3C3C3C3C3C3C3_B2B2B2B2B2B2B2B2_A1A1A1A1A1A1A1A1, -1, 1'b0);

`ifdef CACHELINE_ADAPTOR_LINE_BUF_EN
      do_read(32'h0000_0040, 32'h0000_0040,
              256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101, -1, 1'b0);
      do_read(32'h0000_0040, 32'h0000_0040,
              256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101, -1, 1'b1);
`else
      do_read(32'h0000_0040, 32'h0000_0040,
              256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101, -1, 1'b0);
      do_read(32'h0000_0040, 32'h0000_0040,
              256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101, -1, 1'b0);
`endif

      repeat (3) step();
      chk_a("scoreboard_resp_drained", addr_t'(exp_q.size()), 32'h0);
      chk_a("scoreboard_beats_drained", addr_t'(beat_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
